// File: rtl/amber_core.sv
`default_nettype none
// ============================================================================
// Module  : amber_core (with amber_mem, amber_regcr)
// Brief   : 24-bit CHERI-style core executing CLDcso (capability load) and HLT.
// Revision: 1.0  initial release
// ============================================================================

module amber_mem #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 24,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);
    // Contents are never cleared; images are placed by backdoor.
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

module amber_regcr #(
    parameter int LC_BIT = 2
) (
    input  logic        clk,
    input  logic [1:0]  i_rsel,
    output logic [47:0] o_base,
    output logic [47:0] o_len,
    output logic [47:0] o_cur,
    output logic        o_lc,
    output logic        o_tag,
    input  logic        i_we,
    input  logic [1:0]  i_wsel,
    input  logic [47:0] i_base,
    input  logic [47:0] i_len,
    input  logic [47:0] i_cur,
    input  logic [23:0] i_perms,
    input  logic [23:0] i_attr,
    input  logic        i_tag
);
    logic [47:0] r_base  [4];
    logic [47:0] r_len   [4];
    logic [47:0] r_cur   [4];
    logic [23:0] r_perms [4];
    logic [23:0] r_attr  [4];
    logic        r_tag   [4];

    // All six fields update together so a capability is never half-written.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_base[i_wsel]  <= i_base;
            r_len[i_wsel]   <= i_len;
            r_cur[i_wsel]   <= i_cur;
            r_perms[i_wsel] <= i_perms;
            r_attr[i_wsel]  <= i_attr;
            r_tag[i_wsel]   <= i_tag;
        end
    end

    assign o_base = r_base[i_rsel];
    assign o_len  = r_len[i_rsel];
    assign o_cur  = r_cur[i_rsel];
    assign o_lc   = r_perms[i_rsel][LC_BIT];
    assign o_tag  = r_tag[i_rsel];
endmodule

module amber_core #(
    parameter int         IMEM_DEPTH     = 256,
    parameter int         DMEM_DEPTH     = 1024,
    parameter int         CR_PERM_LC_BIT = 2,
    parameter logic [7:0] OPC_CLDCSO     = 8'h40,
    parameter logic [7:0] OPC_HLT        = 8'hFF
) (
    input  logic iw_clk,
    input  logic iw_rst,
    output logic ow_halted,
    output logic ow_fault
);
    localparam int PC_W = $clog2(IMEM_DEPTH);
    localparam int DA_W = $clog2(DMEM_DEPTH);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_WRITE  = 3'd3;
    localparam logic [2:0] S_HALT   = 3'd4;

    logic [2:0]      r_state;
    logic [PC_W-1:0] r_pc;
    logic [23:0]     r_ir;
    logic [3:0]      r_cnt;
    logic [DA_W-1:0] r_daddr;
    logic            r_fault;
    logic [47:0]     r_ld_base;
    logic [47:0]     r_ld_len;
    logic [47:0]     r_ld_cur;
    logic [23:0]     r_ld_perms;
    logic [23:0]     r_ld_attr;
    logic            r_ld_tag;

    logic [23:0]     w_instr;
    logic [23:0]     w_dword;
    logic [47:0]     w_src_base;
    logic [47:0]     w_src_len;
    logic [47:0]     w_src_cur;
    logic            w_src_lc;
    logic            w_src_tag;
    logic [47:0]     w_addr;
    logic [48:0]     w_end;
    logic [48:0]     w_limit;
    logic            w_cap_fault;
    logic            w_cr_we;
    logic [DA_W-1:0] w_dmem_raddr;

    amber_mem #(.DEPTH(IMEM_DEPTH), .WIDTH(24)) u_imem (
        .clk     (iw_clk),
        .i_we    (1'b0),
        .i_waddr ('0),
        .i_wdata ('0),
        .i_raddr (r_pc),
        .o_rdata (w_instr)
    );

    amber_mem #(.DEPTH(DMEM_DEPTH), .WIDTH(24)) u_dmem (
        .clk     (iw_clk),
        .i_we    (1'b0),
        .i_waddr ('0),
        .i_wdata ('0),
        .i_raddr (w_dmem_raddr),
        .o_rdata (w_dword)
    );

    amber_regcr #(.LC_BIT(CR_PERM_LC_BIT)) u_regcr (
        .clk     (iw_clk),
        .i_rsel  (r_ir[13:12]),
        .o_base  (w_src_base),
        .o_len   (w_src_len),
        .o_cur   (w_src_cur),
        .o_lc    (w_src_lc),
        .o_tag   (w_src_tag),
        .i_we    (w_cr_we),
        .i_wsel  (r_ir[15:14]),
        .i_base  (r_ld_base),
        .i_len   (r_ld_len),
        .i_cur   (r_ld_cur),
        .i_perms (r_ld_perms),
        .i_attr  (r_ld_attr),
        .i_tag   (r_ld_tag)
    );

    // Effective address and a 49-bit bounds check so base+len cannot overflow.
    assign w_addr      = w_src_cur + {{36{r_ir[11]}}, r_ir[11:0]};
    assign w_end       = {1'b0, w_addr} + 49'd12;
    assign w_limit     = {1'b0, w_src_base} + {1'b0, w_src_len};
    assign w_cap_fault = !w_src_tag || !w_src_lc ||
                         (w_addr < w_src_base) || (w_end > w_limit);

    assign w_dmem_raddr = r_daddr + DA_W'(r_cnt);
    assign w_cr_we      = (r_state == S_WRITE) && !iw_rst;
    assign ow_halted    = (r_state == S_HALT);
    assign ow_fault     = r_fault;

    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            r_state <= S_FETCH;
            r_pc    <= '0;
            r_fault <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    r_ir    <= w_instr;
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    if (r_ir[23:16] == OPC_CLDCSO) begin
                        if (w_cap_fault) begin
                            r_fault <= 1'b1;
                            r_state <= S_HALT;
                        end else begin
                            r_daddr <= w_addr[DA_W-1:0];
                            r_cnt   <= '0;
                            r_state <= S_LOAD;
                        end
                    end else if (r_ir[23:16] == OPC_HLT) begin
                        r_state <= S_HALT;
                    end else begin
                        r_pc    <= r_pc + 1'b1;
                        r_state <= S_FETCH;
                    end
                end
                S_LOAD: begin
                    case (r_cnt)
                        4'd0:    r_ld_base[23:0]  <= w_dword;
                        4'd1:    r_ld_base[47:24] <= w_dword;
                        4'd2:    r_ld_len[23:0]   <= w_dword;
                        4'd3:    r_ld_len[47:24]  <= w_dword;
                        4'd4:    r_ld_cur[23:0]   <= w_dword;
                        4'd5:    r_ld_cur[47:24]  <= w_dword;
                        4'd6:    r_ld_perms       <= w_dword;
                        4'd8:    r_ld_attr        <= w_dword;
                        4'd10:   r_ld_tag         <= w_dword[0];
                        default: ;
                    endcase
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'd11) begin
                        r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_pc    <= r_pc + 1'b1;
                    r_state <= S_FETCH;
                end
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_HALT;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_amber_core.sv
`default_nettype none
// ============================================================================
// Module  : tb_amber_core
// Brief   : Randomized and directed checks of amber_core against a program-level model.
// Revision: 1.0  initial release
// ============================================================================
module tb_amber_core;
    localparam logic [7:0]  OPC_CLD = 8'h40;
    localparam logic [7:0]  OPC_HLT = 8'hFF;
    localparam logic [7:0]  OPC_NOP = 8'h12;
    localparam int          LC      = 2;
    localparam logic [63:0] MASK48  = 64'h0000_FFFF_FFFF_FFFF;

    logic iw_clk = 1'b0;
    logic iw_rst = 1'b1;
    logic ow_halted;
    logic ow_fault;

    amber_core u_dut (
        .iw_clk    (iw_clk),
        .iw_rst    (iw_rst),
        .ow_halted (ow_halted),
        .ow_fault  (ow_fault)
    );

    always #5 iw_clk = ~iw_clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [23:0] m_imem [256];
    logic [23:0] m_dmem [1024];
    logic [63:0] m_base [4], m_len [4], m_cur [4], m_perms [4], m_attr [4];
    logic        m_tag  [4];
    logic [63:0] e_base [4], e_len [4], e_cur [4], e_perms [4], e_attr [4];
    logic        e_tag  [4];
    logic        e_fault;
    int          e_cycles;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [23:0] enc_cld(input int crd, input int crs, input int off);
        logic [11:0] o;
        o = 12'(off);
        return {OPC_CLD, 2'(crd), 2'(crs), o};
    endfunction

    // Program-level model: walks the instruction list, applying the capability rules.
    task automatic model_run();
        int pc;
        logic [23:0] w;
        logic [23:0] img [12];
        logic [63:0] a;
        int crd, crs;
        pc = 0;
        for (int i = 0; i < 4; i++) begin
            e_base[i] = m_base[i]; e_len[i] = m_len[i]; e_cur[i] = m_cur[i];
            e_perms[i] = m_perms[i]; e_attr[i] = m_attr[i]; e_tag[i] = m_tag[i];
        end
        e_fault  = 1'b0;
        e_cycles = 0;
        for (int step = 0; step < 64; step++) begin
            w = m_imem[pc];
            e_cycles += 2;
            if (w[23:16] == OPC_HLT) return;
            if (w[23:16] == OPC_CLD) begin
                crd = int'(w[15:14]);
                crs = int'(w[13:12]);
                a = (e_cur[crs] + 64'($signed(w[11:0]))) & MASK48;
                if (!e_tag[crs] || !e_perms[crs][LC] || a < e_base[crs] ||
                    a + 64'd12 > e_base[crs] + e_len[crs]) begin
                    e_fault = 1'b1;
                    return;
                end
                for (int k = 0; k < 12; k++) img[k] = m_dmem[(a + 64'(k)) % 64'd1024];
                e_base[crd]  = {16'h0, img[1], img[0]};
                e_len[crd]   = {16'h0, img[3], img[2]};
                e_cur[crd]   = {16'h0, img[5], img[4]};
                e_perms[crd] = {40'h0, img[6]};
                e_attr[crd]  = {40'h0, img[8]};
                e_tag[crd]   = img[10][0];
                e_cycles += 13;
            end
            pc = (pc + 1) % 256;
        end
    endtask

    task automatic preload();
        for (int i = 0; i < 256; i++)  u_dut.u_imem.r_mem[i] = m_imem[i];
        for (int i = 0; i < 1024; i++) u_dut.u_dmem.r_mem[i] = m_dmem[i];
        for (int i = 0; i < 4; i++) begin
            u_dut.u_regcr.r_base[i]  = m_base[i][47:0];
            u_dut.u_regcr.r_len[i]   = m_len[i][47:0];
            u_dut.u_regcr.r_cur[i]   = m_cur[i][47:0];
            u_dut.u_regcr.r_perms[i] = m_perms[i][23:0];
            u_dut.u_regcr.r_attr[i]  = m_attr[i][23:0];
            u_dut.u_regcr.r_tag[i]   = m_tag[i];
        end
    endtask

    task automatic check_crs(input string name, input int use_model);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_cr%0d_base", name, i),  64'(u_dut.u_regcr.r_base[i]),  use_model != 0 ? e_base[i]  : m_base[i]);
            check($sformatf("%s_cr%0d_len", name, i),   64'(u_dut.u_regcr.r_len[i]),   use_model != 0 ? e_len[i]   : m_len[i]);
            check($sformatf("%s_cr%0d_cur", name, i),   64'(u_dut.u_regcr.r_cur[i]),   use_model != 0 ? e_cur[i]   : m_cur[i]);
            check($sformatf("%s_cr%0d_perms", name, i), 64'(u_dut.u_regcr.r_perms[i]), use_model != 0 ? e_perms[i] : m_perms[i]);
            check($sformatf("%s_cr%0d_attr", name, i),  64'(u_dut.u_regcr.r_attr[i]),  use_model != 0 ? e_attr[i]  : m_attr[i]);
            check($sformatf("%s_cr%0d_tag", name, i),   64'(u_dut.u_regcr.r_tag[i]),   use_model != 0 ? 64'(e_tag[i]) : 64'(m_tag[i]));
        end
    endtask

    // reset_at > 0 re-asserts reset that many cycles into the run.
    task automatic run_case(input string name, input int reset_at);
        int cycles;
        iw_rst = 1'b1;
        @(posedge iw_clk); #1;
        preload();
        model_run();
        @(posedge iw_clk); #1;
        check({name, "_rst_halted"}, 64'(ow_halted), 64'd0);
        check({name, "_rst_fault"}, 64'(ow_fault), 64'd0);
        iw_rst = 1'b0;
        if (reset_at > 0) begin
            repeat (reset_at) @(posedge iw_clk);
            #1;
            iw_rst = 1'b1;
            @(posedge iw_clk); #1;
            check({name, "_mid_pc"}, 64'(u_dut.r_pc), 64'd0);
            check({name, "_mid_halted"}, 64'(ow_halted), 64'd0);
            check_crs({name, "_mid"}, 0);
            iw_rst = 1'b0;
        end
        cycles = 0;
        while (!ow_halted && cycles < 400) begin
            @(posedge iw_clk); #1;
            cycles++;
        end
        check({name, "_cycles"}, 64'(cycles), 64'(e_cycles));
        check({name, "_halted"}, 64'(ow_halted), 64'd1);
        check({name, "_fault"}, 64'(ow_fault), 64'(e_fault));
        check_crs(name, 1);
    endtask

    task automatic random_crs();
        for (int i = 0; i < 4; i++) begin
            m_base[i]  = {$urandom, $urandom} & MASK48;
            m_len[i]   = 64'($urandom_range(2000, 0));
            m_cur[i]   = (m_base[i] + 64'($urandom_range(32'(m_len[i]) + 20, 0))) & MASK48;
            m_perms[i] = 64'($urandom & 32'h00FF_FFFF);
            if ($urandom_range(7, 0) != 0) m_perms[i][LC] = 1'b1;
            m_attr[i]  = 64'($urandom & 32'h00FF_FFFF);
            m_tag[i]   = ($urandom_range(7, 0) != 0);
        end
    endtask

    task automatic set_basic(input int cur, input int off);
        logic [23:0] image [12];
        image = '{24'd42, 24'd7, 24'd88, 24'd9, 24'd123, 24'd3, 24'hEE, 24'd0, 24'hAA, 24'd0, 24'd1, 24'd0};
        for (int i = 0; i < 1024; i++) m_dmem[i] = 24'($urandom);
        for (int i = 0; i < 256; i++)  m_imem[i] = {OPC_HLT, 16'h0};
        random_crs();
        m_base[0] = 64'd0; m_len[0] = 64'd1000; m_cur[0] = 64'(cur);
        m_perms[0] = 64'd1 << LC; m_tag[0] = 1'b1;
        m_base[1] = 64'h1234_5678_9ABC; m_len[1] = 64'h5; m_cur[1] = 64'h77;
        m_perms[1] = 64'h111; m_attr[1] = 64'h222; m_tag[1] = 1'b0;
        for (int k = 0; k < 12; k++) m_dmem[500 + k] = image[k];
        m_imem[0] = enc_cld(1, 0, off);
    endtask

    task automatic check_basic_literal(input string name);
        check({name, "_lit_base"},  64'(u_dut.u_regcr.r_base[1]),  64'h0000_0700_002A);
        check({name, "_lit_len"},   64'(u_dut.u_regcr.r_len[1]),   64'h0000_0900_0058);
        check({name, "_lit_cur"},   64'(u_dut.u_regcr.r_cur[1]),   64'h0000_0300_007B);
        check({name, "_lit_perms"}, 64'(u_dut.u_regcr.r_perms[1]), 64'hEE);
        check({name, "_lit_attr"},  64'(u_dut.u_regcr.r_attr[1]),  64'hAA);
        check({name, "_lit_tag"},   64'(u_dut.u_regcr.r_tag[1]),   64'd1);
        check({name, "_lit_fault"}, 64'(ow_fault), 64'd0);
    endtask

    initial begin
        set_basic(500, 0);   run_case("basic", 0);  check_basic_literal("basic");
        set_basic(490, 10);  run_case("offpos", 0); check_basic_literal("offpos");
        set_basic(510, -10); run_case("offneg", 0); check_basic_literal("offneg");
        set_basic(500, 0);   m_perms[0] = 64'd0; run_case("permfault", 0);
        check("permfault_lit", 64'(ow_fault), 64'd1);
        set_basic(500, 0);   m_tag[0] = 1'b0; run_case("untagged", 0);
        check("untagged_lit", 64'(ow_fault), 64'd1);
        set_basic(990, 0);   run_case("bounds990", 0);
        check("bounds990_lit", 64'(ow_fault), 64'd1);
        set_basic(988, 0);   run_case("bounds988", 0);
        check("bounds988_lit", 64'(ow_fault), 64'd0);
        set_basic(500, 0);   run_case("midreset", 6); check_basic_literal("midreset");

        for (int t = 0; t < 16; t++) begin
            int n;
            for (int i = 0; i < 1024; i++) m_dmem[i] = 24'($urandom);
            for (int i = 0; i < 256; i++)  m_imem[i] = {OPC_HLT, 16'($urandom)};
            random_crs();
            n = $urandom_range(3, 1);
            for (int j = 0; j < n; j++) begin
                if ($urandom_range(3, 0) != 0)
                    m_imem[j] = enc_cld($urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(40, 0) - 20);
                else
                    m_imem[j] = {OPC_NOP, 16'($urandom)};
            end
            run_case($sformatf("rand%0d", t), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
